// File: rtl/shift_unit.sv
// Registered 8-bit shifter: logical and arithmetic shifts in both directions,
// built from three log-shifter stages, with a one-cycle result latency.
module shift_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in,
   input  logic [2:0] num,
   output logic [7:0] out_lsl,
   output logic [7:0] out_rsl,
   output logic [7:0] out_lsa,
   output logic [7:0] out_rsa,
   output logic       out_valid
);

   // Handshake: an operand is accepted on every rising edge where in_valid=1
   // and rst=0; there is no ready, so the source may present one per cycle.
   // out_valid pulses for exactly the cycle after each accepted operand.

   logic [7:0] lsl_s1, lsl_s2, lsl_s4;
   logic [7:0] rsl_s1, rsl_s2, rsl_s4;
   logic [7:0] rsa_s1, rsa_s2, rsa_s4;
   logic       sign;

   logic [7:0] lsl_d, lsl_q;
   logic [7:0] rsl_d, rsl_q;
   logic [7:0] lsa_d, lsa_q;
   logic [7:0] rsa_d, rsa_q;
   logic       valid_d, valid_q;

   assign sign = in[7];

   always_comb begin
      lsl_s1 = num[0] ? {in[6:0], 1'b0}     : in;
      lsl_s2 = num[1] ? {lsl_s1[5:0], 2'b0} : lsl_s1;
      lsl_s4 = num[2] ? {lsl_s2[3:0], 4'b0} : lsl_s2;

      rsl_s1 = num[0] ? {1'b0, in[7:1]}     : in;
      rsl_s2 = num[1] ? {2'b0, rsl_s1[7:2]} : rsl_s1;
      rsl_s4 = num[2] ? {4'b0, rsl_s2[7:4]} : rsl_s2;

      rsa_s1 = num[0] ? {sign, in[7:1]}            : in;
      rsa_s2 = num[1] ? {{2{sign}}, rsa_s1[7:2]}   : rsa_s1;
      rsa_s4 = num[2] ? {{4{sign}}, rsa_s2[7:4]}   : rsa_s2;
   end

   // Data registers hold their contents on idle cycles; only valid clears.
   always_comb begin
      lsl_d   = lsl_q;
      rsl_d   = rsl_q;
      lsa_d   = lsa_q;
      rsa_d   = rsa_q;
      valid_d = in_valid;
      if (in_valid) begin
         lsl_d = lsl_s4;
         rsl_d = rsl_s4;
         lsa_d = lsl_s4;
         rsa_d = rsa_s4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lsl_q   <= 8'h00;
         rsl_q   <= 8'h00;
         lsa_q   <= 8'h00;
         rsa_q   <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         lsl_q   <= lsl_d;
         rsl_q   <= rsl_d;
         lsa_q   <= lsa_d;
         rsa_q   <= rsa_d;
         valid_q <= valid_d;
      end
   end

   assign out_lsl   = lsl_q;
   assign out_rsl   = rsl_q;
   assign out_lsa   = lsa_q;
   assign out_rsa   = rsa_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed and exhaustive bench for shift_unit: hand-computed vectors for the
// documented cases, then all 256x8 operand/amount pairs against a model.
module tb_shift_unit;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in;
   logic [2:0] num;
   logic [7:0] out_lsl, out_rsl, out_lsa, out_rsa;
   logic       out_valid;

   int n_checks;
   int n_pass;

   shift_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in        (in),
      .num       (num),
      .out_lsl   (out_lsl),
      .out_rsl   (out_rsl),
      .out_lsa   (out_lsa),
      .out_rsa   (out_rsa),
      .out_valid (out_valid)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
   endtask

   task automatic check_all(input string tag, input logic [7:0] e_lsl, input logic [7:0] e_rsl,
                            input logic [7:0] e_lsa, input logic [7:0] e_rsa, input logic e_v);
      check({tag, ".lsl"}, out_lsl, e_lsl);
      check({tag, ".rsl"}, out_rsl, e_rsl);
      check({tag, ".lsa"}, out_lsa, e_lsa);
      check({tag, ".rsa"}, out_rsa, e_rsa);
      check({tag, ".vld"}, {7'b0, out_valid}, {7'b0, e_v});
   endtask

   // drive one cycle's inputs, then settle just after the following edge
   task automatic step(input logic r, input logic v, input logic [7:0] i, input logic [2:0] n);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      in       = i;
      num      = n;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] m_rsa(input logic [7:0] x, input int n);
      logic signed [7:0] s;
      s = x;
      return 8'(s >>> n);
   endfunction

   initial begin
      logic [7:0] e_l, e_r, e_a;
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1; in_valid = 1'b0; in = 8'h00; num = 3'd0;

      step(1, 0, 8'h00, 0);
      step(1, 1, 8'hFF, 1);
      check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 0);

      // first valid after reset appears one cycle later
      step(0, 1, 8'h08, 4);
      check_all("v08n4", 8'h80, 8'h00, 8'h80, 8'h00, 1);
      step(0, 1, 8'hF4, 4);
      check_all("vF4n4", 8'h40, 8'h0F, 8'h40, 8'hFF, 1);
      step(0, 1, 8'hD7, 3);
      check_all("vD7n3", 8'hB8, 8'h1A, 8'hB8, 8'hFA, 1);

      // back-to-back
      step(0, 1, 8'h96, 5);
      check_all("v96n5", 8'hC0, 8'h04, 8'hC0, 8'hFC, 1);
      step(0, 1, 8'h18, 2);
      check_all("v18n2", 8'h60, 8'h06, 8'h60, 8'h06, 1);

      // reset wins over a same-cycle operand
      step(1, 1, 8'hD7, 3);
      check_all("rst_prio", 8'h00, 8'h00, 8'h00, 8'h00, 0);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 8'hA5, 3'(k + 1));
         check_all("idle_after_rst", 8'h00, 8'h00, 8'h00, 8'h00, 0);
      end

      // hold on idle cycles with changing inputs
      step(0, 1, 8'hD7, 3);
      check_all("load_D7", 8'hB8, 8'h1A, 8'hB8, 8'hFA, 1);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 8'(8'h3C + k), 3'(k));
         check_all("hold", 8'hB8, 8'h1A, 8'hB8, 8'hFA, 0);
      end

      // mid-stream reset drops the operand scheduled for that edge
      step(0, 1, 8'hF4, 4);
      check_all("pre_mid_rst", 8'h40, 8'h0F, 8'h40, 8'hFF, 1);
      step(1, 1, 8'h08, 4);
      check_all("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00, 0);
      step(0, 1, 8'h81, 7);
      check_all("n7_81", 8'h80, 8'h01, 8'h80, 8'hFF, 1);
      step(0, 1, 8'h7E, 7);
      check_all("n7_7E", 8'h00, 8'h00, 8'h00, 8'h00, 1);

      // exhaustive sweep, back-to-back
      for (int i = 0; i < 256; i++) begin
         for (int n = 0; n < 8; n++) begin
            step(0, 1, 8'(i), 3'(n));
            e_l = 8'(i) << n;
            e_r = 8'(i) >> n;
            e_a = m_rsa(8'(i), n);
            check_all("sweep", e_l, e_r, e_l, e_a, 1);
            if (n == 0) check("sweep.n0_pass", out_rsa, 8'(i));
            if (n == 7) check("sweep.n7_rsa", out_rsa, (i >= 128) ? 8'hFF : 8'h00);
         end
      end

      step(0, 0, 8'h00, 0);
      check("final_vld", {7'b0, out_valid}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 The module SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 The module SHALL expose: rst  input  1  reset, synchronous and active-high.
REQ-003 The module SHALL expose: in_valid  input  1  qualifies in/num this cycle.
REQ-004 The module SHALL expose: in  input  8  operand, unsigned for logical shifts, two's-complement for arithmetic shifts.
REQ-005 The module SHALL expose: num  input  3  shift amount 0..7.
REQ-006 The module SHALL expose: out_lsl  output  8  registered logical left shift.
REQ-007 The module SHALL expose: out_rsl  output  8  registered logical right shift.
REQ-008 The module SHALL expose: out_lsa  output  8  registered arithmetic left shift.
REQ-009 The module SHALL expose: out_rsa  output  8  registered arithmetic right shift.
REQ-010 The module SHALL expose: out_valid  output  1  high for one cycle per accepted operand.
REQ-011 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-012 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-013 out_lsl SHALL equal in shifted left by num, with zeros filled in at the LSBs and bits shifted past bit 7 discarded.
REQ-014 out_rsl SHALL equal in shifted right by num, with zeros filled in at the MSBs and bits shifted past bit 0 discarded.
REQ-015 out_lsa SHALL be bit-identical to out_lsl for every input; no saturation and no overflow flag.
REQ-016 out_rsa SHALL equal in shifted right by num, with copies of in[7] filled in at the MSBs.
REQ-017 num=0 SHALL pass in unchanged to all four outputs.
REQ-018 num=7 SHALL give:
- out_lsl = out_lsa = {in[0],7'b0}
- out_rsl = {7'b0,in[7]}
- out_rsa = 8'h00 or 8'hFF, per in[7].
REQ-019 Each shifter SHALL be a 3-stage log shifter (stages of 1, 2 and 4) controlled by num[0], num[1] and num[2]; no `*` or `/` operators.
REQ-020 Latency SHALL be exactly 1 cycle:
- in_valid=1 at edge N loads all four results, computed from in/num at edge N.
- out_valid=1 after edge N.
REQ-021 When in_valid=0 at an edge:
- the four data outputs SHALL hold their previous values;
- out_valid SHALL be 0.
REQ-022 Back-to-back in_valid=1 SHALL be accepted every cycle with no bubbles; there is no back-pressure input.
REQ-023 Data outputs SHALL change only on rising clk edges and SHALL be glitch-free registered values.

Reset
REQ-024 With rst=1 at a rising edge, all four data outputs SHALL become 8'h00 and out_valid SHALL become 0.
REQ-025 rst SHALL take priority over in_valid in the same cycle; that operand is dropped.
REQ-026 The first valid result after reset SHALL appear one cycle after the first in_valid=1 sampled with rst=0.
REQ-027 Reset asserted mid-stream SHALL drop the result scheduled for that edge, with no partial update.

Verification
REQ-028 in=08 num=4 -> lsl=80 rsl=00 lsa=80 rsa=00.
REQ-029 in=F4 num=4 -> lsl=40 rsl=0F lsa=40 rsa=FF.
REQ-030 in=D7 num=3 -> lsl=B8 rsl=1A lsa=B8 rsa=FA.
REQ-031 in=96 num=5 -> lsl=C0 rsl=04 lsa=C0 rsa=FC; then in=18 num=2 on the next cycle -> lsl=60 rsl=06 lsa=60 rsa=06 (back-to-back, out_valid stays 1).
REQ-032 Apply rst=1 together with in_valid=1 -> outputs 00 and out_valid=0 next cycle. Then drop in_valid for 3 cycles -> outputs hold and out_valid=0.
REQ-033 Sweep all 256×8 input combinations and compare against a reference model one cycle later; include num=0 (outputs equal in) and num=7 (rsa equals 00/FF).
